// File: rtl/h_fir_decimator.sv
// h_fir_decimator: [1,2,1]/4 prefilter plus 16-phase DDA interpolation, one source row in, cfg_tar_w pixels out.
// Ports: clk/rst (sync, active high); cfg_src_w/cfg_tar_w/cfg_step latched on the in_sol beat;
// in_valid/in_ready/in_data/in_sol source stream; out_wr_en/out_ready/out_data row-buffer write; line_done/line_err pulses.
module h_fir_decimator #(
  parameter int W_BITS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_BITS-1:0] cfg_src_w,
  input  logic [W_BITS-1:0] cfg_tar_w,
  input  logic [11:0]       cfg_step,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_sol,
  output logic              out_wr_en,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              line_done,
  output logic              line_err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam logic [W_BITS-1:0] ONE = W_BITS'(1);
  state_t state_q, state_d;
  logic [W_BITS-1:0] src_w_q, src_w_d, tar_w_q, tar_w_d, cnt_q, cnt_d, sidx_q, sidx_d, k_q, k_d;
  logic [11:0] step_q, step_d;
  logic [W_BITS+7:0] pos_q, pos_d;
  logic [7:0] xm_q, xm_d, x0_q, x0_d, sa_q, sa_d, sb_q, sb_d, dout_q, dout_d;
  logic svld_q, svld_d, wen_q, wen_d, last_q, last_d, err_q, err_d;
  logic adv, beat, sol, fill, emit;
  logic [W_BITS-1:0] last_src, i_raw, i0, i1;
  logic [3:0] f;
  logic [7:0] nxt, sel, s_new, y;
  logic [9:0] sum;
  logic [11:0] acc;
  assign out_wr_en = wen_q;
  assign out_data  = dout_q;
  assign line_err  = err_q;
  assign line_done = wen_q && out_ready && last_q;
  always_comb begin
    // The whole pipeline advances only when the output register is free or draining.
    adv = !wen_q || out_ready;
    in_ready = !rst && (state_q == IDLE || (state_q == RUN && adv));
    beat = in_valid && in_ready;
    sol = beat && in_sol;
    last_src = src_w_q - ONE;
    // In FLUSH the right neighbour of the last pixel is the pixel itself (edge replication).
    nxt = state_q == FLUSH ? x0_q : in_data;
    sum = 10'(xm_q) + (10'(x0_q) << 1) + 10'(nxt) + 10'd2;
    s_new = sum[9:2];
    fill = state_q == FLUSH && adv && !(svld_q && sidx_q == last_src);
    i_raw = pos_q[W_BITS+7:8];
    i0 = i_raw > last_src ? last_src : i_raw;
    i1 = i0 < last_src ? i0 + ONE : last_src;
    f = pos_q[7:4];
    // sb holds s[sidx], sa holds s[sidx-1]; i0 equals sidx only when clamped at the row end.
    sel = i0 == sidx_q ? sb_q : sa_q;
    acc = 12'(sel) * 12'(5'd16 - 5'(f)) + 12'(sb_q) * 12'(f) + 12'd8;
    y = acc[11:4];
    emit = adv && !sol && state_q != IDLE && svld_q && k_q < tar_w_q && i1 <= sidx_q;
    state_d = state_q;
    src_w_d = src_w_q;
    tar_w_d = tar_w_q;
    step_d = step_q;
    cnt_d = cnt_q;
    xm_d = xm_q;
    x0_d = x0_q;
    sa_d = sa_q;
    sb_d = sb_q;
    sidx_d = sidx_q;
    svld_d = svld_q;
    pos_d = emit ? pos_q + (W_BITS+8)'(step_q) : pos_q;
    k_d = emit ? k_q + ONE : k_q;
    wen_d = adv ? emit : wen_q;
    dout_d = emit ? y : dout_q;
    last_d = adv ? emit && (k_q + ONE == tar_w_q) : last_q;
    err_d = sol && state_q == RUN;
    if (sol) begin
      state_d = cfg_src_w == ONE ? FLUSH : RUN;
      src_w_d = cfg_src_w;
      tar_w_d = cfg_tar_w;
      step_d = cfg_step;
      xm_d = in_data;
      x0_d = in_data;
      cnt_d = ONE;
      sidx_d = '0;
      svld_d = 1'b0;
      pos_d = '0;
      k_d = '0;
    end else begin
      if (beat && state_q == RUN) begin
        xm_d = x0_q;
        x0_d = in_data;
        sa_d = sb_q;
        sb_d = s_new;
        sidx_d = cnt_q - ONE;
        svld_d = 1'b1;
        cnt_d = cnt_q + ONE;
        state_d = cnt_q + ONE == src_w_q ? FLUSH : RUN;
      end
      if (fill) begin
        sa_d = sb_q;
        sb_d = s_new;
        sidx_d = last_src;
        svld_d = 1'b1;
      end
      if (state_q == FLUSH && k_q == tar_w_q && adv) state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_w_q <= '0;
      tar_w_q <= '0;
      step_q <= '0;
      cnt_q <= '0;
      xm_q <= '0;
      x0_q <= '0;
      sa_q <= '0;
      sb_q <= '0;
      sidx_q <= '0;
      svld_q <= 1'b0;
      pos_q <= '0;
      k_q <= '0;
      wen_q <= 1'b0;
      dout_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_w_q <= src_w_d;
      tar_w_q <= tar_w_d;
      step_q <= step_d;
      cnt_q <= cnt_d;
      xm_q <= xm_d;
      x0_q <= x0_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      sidx_q <= sidx_d;
      svld_q <= svld_d;
      pos_q <= pos_d;
      k_q <= k_d;
      wen_q <= wen_d;
      dout_q <= dout_d;
      last_q <= last_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_h_fir_decimator.sv
// tb_h_fir_decimator: directed scenario tasks against hand-computed rows for h_fir_decimator.
module tb_h_fir_decimator;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sol = 1'b0, out_ready = 1'b1;
  logic [11:0] src_w = 12'd8, tar_w = 12'd8, step = 12'h100;
  logic [7:0] in_data = 8'd0;
  logic in_ready, out_wr_en, line_done, line_err;
  logic [7:0] out_data;
  int checks = 0, passed = 0;
  logic [7:0] got[$];
  int done_at = -1, done_cnt = 0, err_cnt = 0;
  logic [7:0] px[16];
  logic [7:0] e[8];
  h_fir_decimator #(.W_BITS(12)) dut (
    .clk(clk), .rst(rst), .cfg_src_w(src_w), .cfg_tar_w(tar_w), .cfg_step(step),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sol(in_sol),
    .out_wr_en(out_wr_en), .out_ready(out_ready), .out_data(out_data),
    .line_done(line_done), .line_err(line_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (out_wr_en && out_ready) got.push_back(out_data);
    if (line_done) begin
      done_cnt++;
      done_at = got.size();
    end
    if (line_err) err_cnt++;
  end
  task automatic clr();
    got.delete();
    done_at = -1;
    done_cnt = 0;
    err_cnt = 0;
  endtask
  task automatic send(input int n);
    for (int b = 0; b < n; b++) begin
      int t = 0;
      in_valid = 1'b1;
      in_sol = (b == 0);
      in_data = px[b];
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 200);
      if (!in_ready) begin
        checks++;
        $display("FAIL handshake: in_ready=%b required 1 within 200 cycles", in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sol = 1'b0;
  endtask
  task automatic wait_out(input int n);
    int t = 0;
    while ((got.size() < n || !in_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask
  task automatic ramp_cfg();
    src_w = 12'd8; tar_w = 12'd8; step = 12'h100;
    for (int b = 0; b < 8; b++) px[b] = 8'(b * 16);
    e = '{8'd4, 8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd108};
  endtask
  task automatic flat_cfg();
    src_w = 12'd8; tar_w = 12'd4; step = 12'h200;
    for (int b = 0; b < 8; b++) px[b] = 8'd200;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
    @(posedge clk); @(negedge clk);
    checks++; if (out_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", out_wr_en); else passed++;
    checks++; if (out_data !== 8'd0) $display("FAIL reset_data: got %0d want 0", out_data); else passed++;
    checks++; if (line_done !== 1'b0) $display("FAIL reset_done: got %b want 0", line_done); else passed++;
    checks++; if (line_err !== 1'b0) $display("FAIL reset_err: got %b want 0", line_err); else passed++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready); else passed++;
    @(posedge clk); #1;
  endtask
  task automatic test_identity();
    ramp_cfg(); clr();
    send(8); wait_out(8);
    checks++; if (got.size() !== 8) $display("FAIL id_count: got %0d want 8", got.size()); else passed++;
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      checks++; if (got[k] !== e[k]) $display("FAIL id_y%0d: got %0d want %0d", k, got[k], e[k]); else passed++;
    end
    checks++; if (done_at !== 8 || done_cnt !== 1) $display("FAIL id_done: at %0d count %0d want at 8 count 1", done_at, done_cnt); else passed++;
  endtask
  task automatic test_decimate();
    flat_cfg(); clr();
    send(8); wait_out(4);
    checks++; if (got.size() !== 4) $display("FAIL dec_count: got %0d want 4", got.size()); else passed++;
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== 8'd200) $display("FAIL dec_y%0d: got %0d want 200", k, got[k]); else passed++;
    end
    checks++; if (done_at !== 4 || done_cnt !== 1) $display("FAIL dec_done: at %0d count %0d want at 4 count 1", done_at, done_cnt); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL dec_idle: in_ready %b want 1", in_ready); else passed++;
  endtask
  task automatic test_phase();
    src_w = 12'd6; tar_w = 12'd4; step = 12'h180;
    px[0] = 8'd0; px[1] = 8'd0; px[2] = 8'd0; px[3] = 8'd64; px[4] = 8'd64; px[5] = 8'd64;
    e[0] = 8'd0; e[1] = 8'd8; e[2] = 8'd48; e[3] = 8'd64;
    clr();
    send(6); wait_out(4);
    checks++; if (got.size() !== 4) $display("FAIL ph_count: got %0d want 4", got.size()); else passed++;
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== e[k]) $display("FAIL ph_y%0d: got %0d want %0d", k, got[k], e[k]); else passed++;
    end
    checks++; if (done_at !== 4) $display("FAIL ph_done: at %0d want 4", done_at); else passed++;
  endtask
  task automatic test_backpressure();
    logic [7:0] hold;
    ramp_cfg(); clr();
    fork
      send(8);
      begin
        int t = 0;
        while (got.size() < 3 && t < 100) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        hold = out_data;
        checks++; if (out_wr_en !== 1'b1) $display("FAIL bp_pending: wr_en %b want 1", out_wr_en); else passed++;
        repeat (5) begin
          @(negedge clk);
          checks++; if (out_data !== hold || out_wr_en !== 1'b1) $display("FAIL bp_hold: data %0d wr_en %b want %0d 1", out_data, out_wr_en, hold); else passed++;
          checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else passed++;
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_out(8);
    checks++; if (got.size() !== 8) $display("FAIL bp_count: got %0d want 8", got.size()); else passed++;
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      checks++; if (got[k] !== e[k]) $display("FAIL bp_y%0d: got %0d want %0d", k, got[k], e[k]); else passed++;
    end
  endtask
  task automatic test_mid_sol();
    ramp_cfg(); clr();
    send(3);
    flat_cfg();
    send(8); wait_out(4);
    checks++; if (err_cnt !== 1) $display("FAIL sol_err: pulses %0d want 1", err_cnt); else passed++;
    checks++; if (got.size() !== 4) $display("FAIL sol_count: got %0d want 4", got.size()); else passed++;
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== 8'd200) $display("FAIL sol_y%0d: got %0d want 200", k, got[k]); else passed++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL sol_done: count %0d want 1", done_cnt); else passed++;
  endtask
  task automatic test_reset_mid();
    ramp_cfg(); clr();
    send(4);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
    @(posedge clk); @(negedge clk);
    checks++; if (out_wr_en !== 1'b0 || out_data !== 8'd0) $display("FAIL rst_out: wr_en %b data %0d want 0 0", out_wr_en, out_data); else passed++;
    @(posedge clk); #1 rst = 1'b0;
    clr();
    flat_cfg();
    send(8); wait_out(4);
    checks++; if (got.size() !== 4) $display("FAIL rst_count: got %0d want 4", got.size()); else passed++;
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++; if (got[k] !== 8'd200) $display("FAIL rst_y%0d: got %0d want 200", k, got[k]); else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_identity();
    test_decimate();
    test_phase();
    test_backpressure();
    test_mid_sol();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
